// File: rtl/cpu_defs_pkg.sv
// Shared MIPS core definitions: mult/div op encodings, default latencies,
// the hardwired zero register and the mult/div window states.
package cpu_defs;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/md_busy_cnt.sv
// Mult/div busy-window counter: loads the op latency on issue, counts down
// to zero, and flags (sticky) any issue attempted while the window is open.
module md_busy_cnt
    import cpu_defs::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    output logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             done,
    output logic             err
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [0:0]       state;

    // The state is implied by the counter so the two can never disagree.
    assign state = (cnt_q != '0) ? ST_BUSY : ST_IDLE;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    cnt_d = op_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (start) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign cnt  = cnt_q;
    assign busy = (cnt_q != '0);
    assign done = (cnt_q == CNT_W'(1));
    assign err  = err_q;

endmodule

// File: rtl/md_stall_ctrl.sv
// Decode-side stall/bubble controller: holds PC/D and bubbles E on mult/div
// busy windows and load-use hazards, and counts stalled cycles.
module md_stall_ctrl
    import cpu_defs::*;
#(
    parameter int          MULT_LAT      = MULT_LAT_DEF,
    parameter int          DIV_LAT       = DIV_LAT_DEF,
    parameter int          CNT_W         = 4,
    parameter logic [31:0] STALL_CNT_RST = 32'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             md_start_E,
    input  logic [1:0]       md_op_E,
    input  logic             md_use_D,
    input  logic             load_E,
    input  logic [4:0]       wreg_E,
    input  logic [4:0]       rs_D,
    input  logic [4:0]       rt_D,
    input  logic             rs_use_D,
    input  logic             rt_use_D,
    output logic             stall,
    output logic             clr_E,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] md_cnt,
    output logic             md_err,
    output logic [31:0]      stall_cnt
);

    logic        op_div;
    logic        md_stall;
    logic        lu_stall;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    assign op_div = (md_op_E == MD_DIV) || (md_op_E == MD_DIVU);

    md_busy_cnt #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) u_md_busy_cnt (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start_E),
        .op_div (op_div),
        .cnt    (md_cnt),
        .busy   (md_busy),
        .done   (md_done),
        .err    (md_err)
    );

    // The issue cycle itself must stall a dependent D instruction, hence md_start_E.
    assign md_stall = md_use_D & (md_start_E | md_busy);
    assign lu_stall = load_E & (wreg_E != REG_ZERO) &
                      ((rs_use_D & (rs_D == wreg_E)) | (rt_use_D & (rt_D == wreg_E)));

    assign stall = md_stall | lu_stall;
    assign clr_E = stall;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= STALL_CNT_RST;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_md_stall_ctrl.sv
// Directed bench for md_stall_ctrl; a second instance starts its stall
// counter next to the top so saturation can be observed quickly.
module tb_md_stall_ctrl;
    import cpu_defs::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        md_start_E;
    logic [1:0]  md_op_E;
    logic        md_use_D;
    logic        load_E;
    logic [4:0]  wreg_E, rs_D, rt_D;
    logic        rs_use_D, rt_use_D;

    logic        stall, clr_E, md_busy, md_done, md_err;
    logic [3:0]  md_cnt;
    logic [31:0] stall_cnt;

    logic        s_stall, s_clr_E, s_md_busy, s_md_done, s_md_err;
    logic [3:0]  s_md_cnt;
    logic [31:0] s_stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    md_stall_ctrl dut (
        .clk(clk), .reset(reset), .md_start_E(md_start_E), .md_op_E(md_op_E),
        .md_use_D(md_use_D), .load_E(load_E), .wreg_E(wreg_E), .rs_D(rs_D),
        .rt_D(rt_D), .rs_use_D(rs_use_D), .rt_use_D(rt_use_D),
        .stall(stall), .clr_E(clr_E), .md_busy(md_busy), .md_done(md_done),
        .md_cnt(md_cnt), .md_err(md_err), .stall_cnt(stall_cnt)
    );

    md_stall_ctrl #(.STALL_CNT_RST(32'hFFFF_FFFE)) dut_sat (
        .clk(clk), .reset(reset), .md_start_E(md_start_E), .md_op_E(md_op_E),
        .md_use_D(md_use_D), .load_E(load_E), .wreg_E(wreg_E), .rs_D(rs_D),
        .rt_D(rt_D), .rs_use_D(rs_use_D), .rt_use_D(rt_use_D),
        .stall(s_stall), .clr_E(s_clr_E), .md_busy(s_md_busy), .md_done(s_md_done),
        .md_cnt(s_md_cnt), .md_err(s_md_err), .stall_cnt(s_stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; md_start_E = 1'b0; md_op_E = MD_MULT; md_use_D = 1'b0;
        load_E = 1'b0; wreg_E = '0; rs_D = '0; rt_D = '0; rs_use_D = 1'b0; rt_use_D = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_cnt", 32'(md_cnt), 0);
        chk("rst_busy", 32'(md_busy), 0);
        chk("rst_done", 32'(md_done), 0);
        chk("rst_err", 32'(md_err), 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_sat_cnt", s_stall_cnt, 32'hFFFF_FFFE);

        // mult countdown
        md_start_E = 1'b1; md_op_E = MD_MULT;
        #1 chk("mult_c0_cnt", 32'(md_cnt), 0);
        tick();
        md_start_E = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            #1;
            chk($sformatf("mult_c%0d_cnt", i), 32'(md_cnt), 32'(6 - i));
            chk($sformatf("mult_c%0d_done", i), 32'(md_done), (i == 5) ? 1 : 0);
            tick();
        end
        #1 chk("mult_c6_busy", 32'(md_busy), 0);

        // div with dependent mflo in D
        md_start_E = 1'b1; md_op_E = MD_DIV; md_use_D = 1'b1;
        #1;
        chk("div_c0_stall", 32'(stall), 1);
        chk("div_c0_clrE", 32'(clr_E), 1);
        tick();
        md_start_E = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            #1;
            chk($sformatf("div_c%0d_stall", c), 32'(stall), 1);
            chk($sformatf("div_c%0d_cnt", c), 32'(md_cnt), 32'(11 - c));
            tick();
        end
        #1;
        chk("div_c11_stall", 32'(stall), 0);
        chk("div_c11_stall_cnt", stall_cnt, 11);
        md_use_D = 1'b0;

        // load-use hazards
        load_E = 1'b1; wreg_E = 5'd8; rs_D = 5'd8; rs_use_D = 1'b1;
        #1 chk("lu_rs_stall", 32'(stall), 1);
        tick();
        load_E = 1'b0;
        #1;
        chk("lu_next_stall", 32'(stall), 0);
        chk("lu_stall_cnt", stall_cnt, 12);
        load_E = 1'b1; rs_D = 5'd3; rs_use_D = 1'b0; rt_D = 5'd8; rt_use_D = 1'b1;
        #1 chk("lu_rt_stall", 32'(stall), 1);
        rt_use_D = 1'b0; wreg_E = 5'd0; rs_D = 5'd0; rs_use_D = 1'b1;
        #1 chk("lu_r0_stall", 32'(stall), 0);
        wreg_E = 5'd8; rs_D = 5'd8; rs_use_D = 1'b0;
        #1 chk("lu_nouse_stall", 32'(stall), 0);
        rs_D = 5'd9; rs_use_D = 1'b1;
        #1 chk("lu_diff_stall", 32'(stall), 0);
        load_E = 1'b0; rs_use_D = 1'b0;
        tick();
        #1 chk("lu_cnt_hold", stall_cnt, 12);

        // start while busy
        md_start_E = 1'b1; md_op_E = MD_MULT;
        tick();
        md_start_E = 1'b0;
        #1 chk("err_cnt5", 32'(md_cnt), 5);
        tick(); tick();
        #1 chk("err_cnt3", 32'(md_cnt), 3);
        md_start_E = 1'b1; md_op_E = MD_DIV;
        #1 chk("err_pre", 32'(md_err), 0);
        tick();
        md_start_E = 1'b0;
        #1;
        chk("err_set", 32'(md_err), 1);
        chk("err_cnt2", 32'(md_cnt), 2);
        tick();
        #1 chk("err_cnt1", 32'(md_cnt), 1);
        md_start_E = 1'b1;
        tick();
        md_start_E = 1'b0;
        #1;
        chk("err_cnt0", 32'(md_cnt), 0);
        chk("err_sticky", 32'(md_err), 1);
        md_start_E = 1'b1; md_op_E = MD_MULTU;
        tick();
        md_start_E = 1'b0;
        #1;
        chk("err_idle_load", 32'(md_cnt), 5);
        chk("err_still", 32'(md_err), 1);
        repeat (5) tick();

        // reset mid-window
        md_start_E = 1'b1; md_op_E = MD_DIVU;
        tick();
        md_start_E = 1'b0;
        tick(); tick(); tick();
        #1 chk("rmid_cnt7", 32'(md_cnt), 7);
        reset = 1'b1;
        #1;
        chk("rmid_cnt", 32'(md_cnt), 0);
        chk("rmid_busy", 32'(md_busy), 0);
        chk("rmid_err", 32'(md_err), 0);
        chk("rmid_stall_cnt", stall_cnt, 0);
        tick();
        reset = 1'b0; md_start_E = 1'b1; md_op_E = MD_MULT;
        tick();
        md_start_E = 1'b0;
        #1 chk("rmid_mult_load", 32'(md_cnt), 5);

        // both causes at once, and saturation
        md_use_D = 1'b1; load_E = 1'b1; wreg_E = 5'd8; rs_D = 5'd8; rs_use_D = 1'b1;
        #1 chk("both_stall", 32'(stall), 1);
        tick();
        load_E = 1'b0; rs_use_D = 1'b0; md_use_D = 1'b0;
        #1;
        chk("both_cnt", stall_cnt, 1);
        chk("sat_reach", s_stall_cnt, 32'hFFFF_FFFF);
        md_use_D = 1'b1;
        tick(); tick(); tick();
        md_use_D = 1'b0;
        #1;
        chk("sat_hold", s_stall_cnt, 32'hFFFF_FFFF);
        chk("more_cnt", stall_cnt, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/md_stall_ctrl.md
Name: md_stall_ctrl

Overview:
- Pipeline stall/bubble controller for the five-stage MIPS core. It sequences the multiply/divide unit's busy window and detects load-use hazards.
- It freezes the PC and the D register and inserts a bubble into the E register, so dependent instructions reach the M/W registers only once operands are valid.
- It sits beside the decode stage and drives the enable/clear inputs of the pipeline registers.

Parameters:
- MULT_LAT, 5, busy cycles for mult/multu after issue
- DIV_LAT, 10, busy cycles for div/divu after issue
- CNT_W, 4, counter width; must hold max(MULT_LAT, DIV_LAT)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- md_start_E  input  1  mult/div instruction in E this cycle
- md_op_E  input  2  00 mult, 01 multu, 10 div, 11 divu
- md_use_D  input  1  D-stage instruction is mfhi/mflo/mthi/mtlo/mult/multu/div/divu
- load_E  input  1  E-stage instruction is a load
- wreg_E  input  5  E-stage destination register
- rs_D  input  5  D-stage rs field
- rt_D  input  5  D-stage rt field
- rs_use_D  input  1  D-stage reads rs
- rt_use_D  input  1  D-stage reads rt
- stall  output  1  hold PC and D register (enable = ~stall)
- clr_E  output  1  synchronous clear of E register (bubble)
- md_busy  output  1  mult/div window active
- md_done  output  1  last busy cycle; HI/LO valid next cycle
- md_cnt  output  CNT_W  remaining busy cycles
- md_err  output  1  sticky: start seen while busy
- stall_cnt  output  32  count of stalled cycles

Behaviour:
- Reset (async, active-high) forces the following values immediately. md_cnt=0, md_busy=0, md_done=0, md_err=0, stall_cnt=0, FSM=IDLE.
- FSM states:
  - IDLE (md_cnt==0).
  - BUSY (md_cnt!=0).
- IDLE→BUSY occurs at the edge ending a cycle with md_start_E=1. md_cnt is loaded with MULT_LAT when md_op_E[1]=0, else DIV_LAT.
- In BUSY, md_cnt decrements by 1 on every edge. BUSY→IDLE occurs when md_cnt goes 1→0.
- md_busy = (md_cnt!=0), registered-derived with no combinational path from md_start_E.
- md_done = (md_cnt==1), combinational from the counter.
- md_start_E while BUSY: the counter is not reloaded, md_err is set and stays set until reset. The window continues unchanged. A start in the cycle md_cnt==1 is also an error.
- md_stall = md_use_D & (md_start_E | md_busy). The start cycle itself stalls a dependent D instruction.
- lu_stall = load_E & (wreg_E!=0) & ((rs_use_D & rs_D==wreg_E) | (rt_use_D & rt_D==wreg_E)). Register 0 never causes a stall.
- stall = md_stall | lu_stall, combinational, with zero-cycle latency to the pipeline register enables.
- clr_E = stall, so the instruction held in D is not duplicated into E.
- stall_cnt increments on every edge where stall=1 and saturates at 0xFFFFFFFF.
- Both stall causes may be active in the same cycle: stall is asserted once and stall_cnt increments by 1.
- Reset mid-operation abandons the mult/div window. A later start behaves as from IDLE.

Decomposition:
- Shared package (cpu_defs) holds:
  - MD_MULT, MD_MULTU, MD_DIV, MD_DIVU 2-bit encodings
  - MULT_LAT/DIV_LAT defaults
  - the zero-register constant
- One natural sub-module, md_busy_cnt: the load/decrement counter with the done/busy/err flags.
- Hazard compare and stall counter stay in the top module.

Test Plan:
1. Reset mid-BUSY (div issued, md_cnt=7, assert reset) → md_cnt=0, md_busy=0 immediately. A mult issued after reset loads 5.
2. md_start_E=1, md_op_E=00 at cycle 0 → md_cnt reads 5,4,3,2,1 in cycles 1–5. md_done=1 only in cycle 5; md_busy=0 in cycle 6.
3. div issue (md_op_E=10) with mflo in D (md_use_D=1) over cycles 0–10:
   - stall=1 and clr_E=1 in cycles 0–10 (cycle 0 from md_start_E, 1–10 from md_busy), stall=0 in cycle 11
   - stall_cnt=11 at cycle 11
4. load_E=1, wreg_E=8, rs_D=8, rs_use_D=1 → stall=1 for exactly that cycle. The same case with wreg_E=0, or with rs_use_D=0, gives stall=0.
5. md_start_E pulsed while md_cnt=3 → md_err=1 and stays 1. md_cnt continues 2,1,0 with no reload.
6. lu_stall and md_stall asserted in the same cycle → stall=1 and stall_cnt+1. Preload stall_cnt to 0xFFFFFFFF: it remains 0xFFFFFFFF while stalled.
